// File: rtl/fp_normalize_round.sv
// Two-stage float32 result packer: stage A aligns each lane's magnitude to the hidden-bit
// position, stage B rounds to nearest-even and packs sign/exponent/fraction.
module fp_normalize_round #(
  parameter int NUM_LANES    = 16,
  parameter int INSTR_W      = 64,
  parameter int THREAD_IDX_W = 2,
  parameter int SUBCYCLE_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wb_rollback_en,
  input  logic [THREAD_IDX_W-1:0]   wb_rollback_thread_idx,
  input  logic                      in_valid,
  input  logic [INSTR_W-1:0]        in_instruction,
  input  logic [NUM_LANES-1:0]      in_mask,
  input  logic [THREAD_IDX_W-1:0]   in_thread_idx,
  input  logic [SUBCYCLE_W-1:0]     in_subcycle,
  input  logic [NUM_LANES*32-1:0]   in_significand,
  input  logic [NUM_LANES*8-1:0]    in_exponent,
  input  logic [NUM_LANES-1:0]      in_sign,
  input  logic [NUM_LANES-1:0]      in_nan,
  input  logic [NUM_LANES-1:0]      in_inf,
  output logic                      nr_valid,
  output logic [INSTR_W-1:0]        nr_instruction,
  output logic [NUM_LANES-1:0]      nr_mask,
  output logic [THREAD_IDX_W-1:0]   nr_thread_idx,
  output logic [SUBCYCLE_W-1:0]     nr_subcycle,
  output logic [NUM_LANES*32-1:0]   nr_result
);

  typedef struct packed {
    logic [31:0] sig;
    logic [7:0]  exp;
    logic        sign;
    logic        nan;
    logic        inf;
    logic        ovf;
  } lane_a_t;

  function automatic logic [5:0] lead_one(input logic [31:0] v);
    logic [5:0] idx;
    idx = '0;
    for (int b = 0; b < 32; b++) begin
      if (v[b]) idx = 6'(b);
    end
    return idx;
  endfunction

  // Right shift that folds every discarded bit into bit 0 so rounding still sees them.
  function automatic logic [31:0] shr_sticky(input logic [31:0] v, input logic [9:0] amt);
    logic [31:0] lost_mask;
    if (amt >= 10'd31) return {31'b0, |v};
    lost_mask = ~(32'hffff_ffff << amt);
    return (v >> amt) | {31'b0, |(v & lost_mask)};
  endfunction

  function automatic lane_a_t normalize_lane(input logic [31:0] sig, input logic [7:0] exp,
                                             input logic sign, input logic nan, input logic inf);
    lane_a_t            r;
    logic signed [9:0]  shift;
    logic signed [9:0]  new_exp;
    logic signed [9:0]  sub_shift;
    r.sig  = '0;
    r.exp  = '0;
    r.sign = sign;
    r.nan  = nan;
    r.inf  = inf;
    r.ovf  = 1'b0;
    shift     = $signed({4'b0, lead_one(sig)}) - 10'sd26;
    new_exp   = $signed({2'b0, exp}) + shift;
    sub_shift = 10'sd1 - $signed({2'b0, exp});
    if (sig != '0) begin
      if (new_exp >= 10'sd1) begin
        r.exp = new_exp[7:0];
        r.ovf = (new_exp >= 10'sd255);
        if (shift > 10'sd0) r.sig = shr_sticky(sig, shift);
        else                r.sig = sig << (-shift);
      end else begin
        // Subnormal: align so bit 3 carries weight 2^-149, exponent field stays 0.
        if (sub_shift > 10'sd0) r.sig = shr_sticky(sig, sub_shift);
        else                    r.sig = sig << (-sub_shift);
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] pack_lane(input lane_a_t a);
    logic [24:0] mr;
    logic [8:0]  e;
    logic        round_up;
    logic        ovf;
    round_up = a.sig[2] & (a.sig[1] | a.sig[0] | a.sig[3]);
    mr       = {1'b0, a.sig[26:3]} + 25'(round_up);
    e        = {1'b0, a.exp};
    ovf      = a.ovf;
    if (a.exp != 8'd0) begin
      if (mr[24]) begin
        mr = mr >> 1;
        e  = e + 9'd1;
      end
      if (e >= 9'd255) ovf = 1'b1;
    end else if (mr[23]) begin
      e = 9'd1;
    end
    if (a.nan)       return 32'h7fff_ffff;
    if (a.inf | ovf) return {a.sign, 8'hff, 23'h0};
    if (a.sig == '0) return {a.sign, 31'h0};
    return {a.sign, e[7:0], mr[22:0]};
  endfunction

  logic                    a_valid_d, a_valid_q;
  logic [INSTR_W-1:0]      a_instruction_d, a_instruction_q;
  logic [NUM_LANES-1:0]    a_mask_d, a_mask_q;
  logic [THREAD_IDX_W-1:0] a_thread_idx_d, a_thread_idx_q;
  logic [SUBCYCLE_W-1:0]   a_subcycle_d, a_subcycle_q;
  lane_a_t                 a_lane_d [NUM_LANES];
  lane_a_t                 a_lane_q [NUM_LANES];

  logic                    nr_valid_d, nr_valid_q;
  logic [INSTR_W-1:0]      nr_instruction_d, nr_instruction_q;
  logic [NUM_LANES-1:0]    nr_mask_d, nr_mask_q;
  logic [THREAD_IDX_W-1:0] nr_thread_idx_d, nr_thread_idx_q;
  logic [SUBCYCLE_W-1:0]   nr_subcycle_d, nr_subcycle_q;
  logic [NUM_LANES*32-1:0] nr_result_d, nr_result_q;

  // NOTE: every _d is assigned on every path (defaults first), so no latches are inferred.
  always_comb begin
    a_valid_d  = in_valid & ~(wb_rollback_en && (wb_rollback_thread_idx == in_thread_idx));
    nr_valid_d = a_valid_q & ~(wb_rollback_en && (wb_rollback_thread_idx == a_thread_idx_q));

    a_instruction_d = in_instruction;
    a_mask_d        = in_mask;
    a_thread_idx_d  = in_thread_idx;
    a_subcycle_d    = in_subcycle;

    nr_instruction_d = a_instruction_q;
    nr_mask_d        = a_mask_q;
    nr_thread_idx_d  = a_thread_idx_q;
    nr_subcycle_d    = a_subcycle_q;
    nr_result_d      = '0;

    // Masked-off lanes are computed like any other; the mask only travels alongside.
    for (int i = 0; i < NUM_LANES; i++) begin
      a_lane_d[i] = normalize_lane(in_significand[i*32 +: 32], in_exponent[i*8 +: 8],
                                   in_sign[i], in_nan[i], in_inf[i]);
      nr_result_d[i*32 +: 32] = pack_lane(a_lane_q[i]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so each flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_valid_q  <= 1'b0;
      nr_valid_q <= 1'b0;
    end else begin
      a_valid_q  <= a_valid_d;
      nr_valid_q <= nr_valid_d;
    end
  end

  // NOTE: payload flops carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    a_instruction_q  <= a_instruction_d;
    a_mask_q         <= a_mask_d;
    a_thread_idx_q   <= a_thread_idx_d;
    a_subcycle_q     <= a_subcycle_d;
    a_lane_q         <= a_lane_d;
    nr_instruction_q <= nr_instruction_d;
    nr_mask_q        <= nr_mask_d;
    nr_thread_idx_q  <= nr_thread_idx_d;
    nr_subcycle_q    <= nr_subcycle_d;
    nr_result_q      <= nr_result_d;
  end

  assign nr_valid       = nr_valid_q;
  assign nr_instruction = nr_instruction_q;
  assign nr_mask        = nr_mask_q;
  assign nr_thread_idx  = nr_thread_idx_q;
  assign nr_subcycle    = nr_subcycle_q;
  assign nr_result      = nr_result_q;

endmodule

// File: doc/fp_normalize_round.md
# fp_normalize_round

Floating-point result packer for the vector FP pipeline: the inverse of the operand-unpack stage. The unpack stage splits float32 operands into sign, exponent and hidden-bit significand. This block takes each lane's unnormalized magnitude, exponent, sign and special-case flags, normalizes and rounds them (round-to-nearest-even), and packs a float32 result. It is a 2-stage pipeline that sits between the FP adder/multiplier result stages and writeback, with per-thread rollback squash.

## Interface
- NUM_LANES, 16, vector lanes processed in parallel
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; when low, clears all valid bits immediately
- wb_rollback_en  in  1  rollback request from writeback
- wb_rollback_thread_idx  in  local_thread_idx_t  thread being rolled back
- in_valid  in  1  input instruction valid
- in_instruction  in  decoded_instruction_t  passed through unchanged
- in_mask  in  vector_mask_t  passed through unchanged
- in_thread_idx  in  local_thread_idx_t  passed through; compared against rollback
- in_subcycle  in  subcycle_t  passed through
- in_significand  in  NUM_LANES x 32  unnormalized magnitude; nominal hidden-bit position is bit 26; bits 2/1/0 are guard/round/sticky
- in_exponent  in  NUM_LANES x 8  biased exponent valid when the leading one is at bit 26
- in_sign  in  NUM_LANES x 1  result sign
- in_nan / in_inf  in  NUM_LANES x 1 each  special-case overrides; nan has priority
- nr_valid  out  1  result valid
- nr_instruction, nr_mask, nr_thread_idx, nr_subcycle  out  (as inputs)  delayed copies
- nr_result  out  NUM_LANES x 32  packed float32 per lane

## Operation
- Value represented per lane: in_significand × 2^(in_exponent − 127 − 26).
- Stage A (leading-one detect, shift):
  - lead = index of the most significant one; shift = lead − 26 (signed); new_exp = in_exponent + shift (10-bit signed).
  - Zero significand: the lane is zero; exponent field 0.
  - Normal (new_exp ≥ 1):
    - shift > 0: right shift by shift; exponent field = new_exp.
    - Otherwise: left shift by −shift.
  - Subnormal (new_exp ≤ 0): shift by s = 1 − in_exponent relative to the bit-26 alignment, right if positive, left if negative; exponent field = 0.
  - Every right shift ORs all bits shifted out into bit 0 (sticky). Right shifts ≥ 31 saturate: the result is sticky only.
  - new_exp ≥ 255 before rounding: flag overflow.
  - Register the shifted significand, exponent field, sign, nan, inf and overflow, plus the control fields.
- Stage B (round, pack):
  - m = bits[26:3] (24 bits); g = bit2, r = bit1, s = bit0.
  - round_up = g & (r | s | m[0]); m' = m + round_up.
  - Normal lane: if m' carries to bit 24, m' >>= 1 and exponent += 1. Exponent reaching 255 becomes overflow.
  - Subnormal lane: if m' reaches 2^23, the exponent field becomes 1 and the fraction becomes 0.
  - Result priority per lane:
    - nan → 32'h7fffffff
    - else inf or overflow → {sign, 8'hff, 23'h0}
    - else zero → {sign, 31'h0}
    - else {sign, exp, m'[22:0]}.
- Masked-off lanes are computed anyway. The mask is forwarded unchanged.
- Rollback: at each stage boundary, clear the stage valid if wb_rollback_en and wb_rollback_thread_idx equals that stage's thread_idx. This applies both at input capture and at the A→B transfer.

## Timing
- Latency 2: inputs sampled at edge N produce nr_* visible after edge N+2. Throughput is 1 per cycle with no stall and no backpressure.
- Reset low: stage A valid and nr_valid are cleared asynchronously. Data registers are not reset and are don't-care while valid is 0.
- Reset deasserted: the first possible nr_valid is 2 edges after the first in_valid accepted.
- Reset mid-operation: in-flight instructions are lost; no partial result appears.
- Simultaneous rollback and new input for the same thread: the input is dropped. Other threads are unaffected. A stage-A entry for the rolled-back thread is also dropped in the same cycle.
- Back-to-back instructions from different threads flow independently.

## Test plan
- sig=0x04000000, exp=127, sign=0 → nr_result 0x3f800000. sig=0x08000000, exp=127 → 0x40000000.
- Round to even:
  - sig=0x04000004, exp=127 → 0x3f800000 (tie, even, no increment).
  - sig=0x0400000C → 0x3f800002.
  - sig=0x07FFFFFC, exp=127 → carry renormalize → 0x40000000.
- Overflow/special: sig=0x08000000, exp=254 → 0x7f800000. in_nan=1 with in_inf=1 → 0x7fffffff. sig=0, sign=1 → 0x80000000.
- Subnormal: sig=0x04000000, exp=0 → 0x00400000. sig=0x07FFFFFC, exp=0 → 0x00800000 (rounds up into exponent 1).
- Rollback: in_valid for thread 2 at edge N, rollback thread 2 during cycle N+1 → nr_valid stays 0. A thread-1 instruction issued at N+1 still emerges at N+3.
- Reset pulse low while two instructions are in flight → nr_valid 0 immediately and on the next two edges. A fresh input after release emerges correctly 2 cycles later.
